// File: rtl/board_scan_reader.sv
// Read-side master for the game-board memory: walks every cell in row-major order,
// issues one read per cell, and presents each returned word on a valid/ready stream.
module board_scan_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000,
  parameter int          ROWS       = 10,
  parameter int          COLS       = 10,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [31:0] cell_data,
  output logic [3:0]  cell_row,
  output logic [3:0]  cell_col,
  output logic        cell_last,
  output logic        busy,
  output logic        done,
  output logic [6:0]  nonzero_count
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_DONE} state_t;

  localparam logic [2:0] LAT      = 3'(RD_LATENCY);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_row;
  logic [3:0]  r_col;
  logic [2:0]  r_lat;
  logic [31:0] r_data;
  logic [6:0]  r_nz;
  logic        w_last_cell;
  logic        w_capture;
  logic        w_hs;
  logic        w_accept;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  assign w_last_cell = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_accept    = (r_state == S_IDLE) && start;
  // r_lat holds the 1-based cycle number of the read while in WAIT
  assign w_capture   = !abort && (((r_state == S_ISSUE) && (LAT == 3'd1)) ||
                                  ((r_state == S_WAIT) && (r_lat == LAT)));
  assign w_hs        = (r_state == S_PRESENT) && cell_ready && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ISSUE;
      S_ISSUE:   if (abort) w_next = S_IDLE;
                 else if (LAT == 3'd1) w_next = S_PRESENT;
                 else w_next = S_WAIT;
      S_WAIT:    if (abort) w_next = S_IDLE;
                 else if (r_lat == LAT) w_next = S_PRESENT;
      S_PRESENT: if (abort) w_next = S_IDLE;
                 else if (cell_ready) w_next = w_last_cell ? S_DONE : S_ISSUE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    cell_valid = 1'b0;
    cell_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_ISSUE, S_WAIT: begin
        mem_read = 1'b1;
        busy     = 1'b1;
      end
      S_PRESENT: begin
        cell_valid = 1'b1;
        cell_last  = w_last_cell;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= 4'd0;
      r_col  <= 4'd0;
      r_lat  <= 3'd0;
      r_data <= 32'd0;
      r_nz   <= 7'd0;
    end else begin
      if (w_accept) begin
        r_row <= 4'd0;
        r_col <= 4'd0;
        r_nz  <= 7'd0;
      end else if (w_hs && !w_last_cell) begin
        if (r_col == LAST_COL) begin
          r_col <= 4'd0;
          r_row <= r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
      if (r_state == S_ISSUE)     r_lat <= 3'd2;
      else if (r_state == S_WAIT) r_lat <= r_lat + 3'd1;
      if (w_capture) begin
        r_data <= mem_data;
        if (mem_data != 32'd0) r_nz <= sat_inc(r_nz);
      end
    end
  end

  assign mem_addr      = BASE_ADDR + ((32'(r_row) * 32'(COLS) + 32'(r_col)) << 2);
  assign cell_data     = r_data;
  assign cell_row      = r_row;
  assign cell_col      = r_col;
  assign nonzero_count = r_nz;

endmodule

// File: tb/tb_board_scan_reader.sv
// Bench for board_scan_reader: one instance with single-cycle reads, one with 3-cycle
// reads, a shared board memory model and a cell-level scoreboard.
module tb_board_scan_reader;

  localparam int          N    = 100;
  localparam logic [31:0] BASE = 32'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic        abort [2];
  logic        cell_ready [2];
  logic        mem_read [2];
  logic        cell_valid [2];
  logic        cell_last [2];
  logic        busy [2];
  logic        done [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_data [2];
  logic [31:0] cell_data [2];
  logic [3:0]  cell_row [2];
  logic [3:0]  cell_col [2];
  logic [6:0]  nonzero_count [2];

  logic [31:0] board [N];
  int          rcnt [2] = '{0, 0};
  int          checks = 0;
  int          errors = 0;

  bit          m_busy [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  int          m_idx [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          last_cnt [2] = '{0, 0};
  logic [31:0] addr_q [$];

  always #5 clk = ~clk;

  board_scan_reader #(.BASE_ADDR(32'h1000), .ROWS(10), .COLS(10), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .mem_read(mem_read[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
    .cell_valid(cell_valid[0]), .cell_ready(cell_ready[0]), .cell_data(cell_data[0]),
    .cell_row(cell_row[0]), .cell_col(cell_col[0]), .cell_last(cell_last[0]),
    .busy(busy[0]), .done(done[0]), .nonzero_count(nonzero_count[0]));

  board_scan_reader #(.BASE_ADDR(32'h1000), .ROWS(10), .COLS(10), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .mem_read(mem_read[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
    .cell_valid(cell_valid[1]), .cell_ready(cell_ready[1]), .cell_data(cell_data[1]),
    .cell_row(cell_row[1]), .cell_col(cell_col[1]), .cell_last(cell_last[1]),
    .busy(busy[1]), .done(done[1]), .nonzero_count(nonzero_count[1]));

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int nz_upto(input int k);
    int c;
    c = 0;
    for (int i = 0; i < k; i++) if (board[i] != 32'd0 && c < 127) c++;
    return c;
  endfunction

  // Memory returns valid data only in the last cycle of each read; garbage otherwise.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) rcnt[u] <= mem_read[u] ? rcnt[u] + 1 : 0;
  end

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      mem_data[u] = 32'hDEAD_BEEF;
      if (mem_read[u] && rcnt[u] == lat_of(u) - 1 &&
          mem_addr[u] >= BASE && mem_addr[u] < BASE + 32'(4 * N))
        mem_data[u] = board[int'((mem_addr[u] - BASE) >> 2)];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input int u, input string tag);
    chk({tag, "_mem_read"}, 32'(mem_read[u]), 0);
    chk({tag, "_mem_addr"}, mem_addr[u], 32'h1000);
    chk({tag, "_valid"}, 32'(cell_valid[u]), 0);
    chk({tag, "_data"}, cell_data[u], 0);
    chk({tag, "_row"}, 32'(cell_row[u]), 0);
    chk({tag, "_col"}, 32'(cell_col[u]), 0);
    chk({tag, "_last"}, 32'(cell_last[u]), 0);
    chk({tag, "_busy"}, 32'(busy[u]), 0);
    chk({tag, "_done"}, 32'(done[u]), 0);
    chk({tag, "_nz"}, 32'(nonzero_count[u]), 0);
  endtask

  // Scoreboard: cell index of the next expected cell, scan phase, expected outputs.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        chk_reset_vals(u, "rst");
        m_busy[u] = 1'b0;
        m_done[u] = 1'b0;
        m_idx[u]  = 0;
      end else begin
        chk("busy", 32'(busy[u]), 32'(m_busy[u]));
        chk("done", 32'(done[u]), 32'(m_done[u]));
        if (m_busy[u]) begin
          if (mem_read[u]) chk("mem_addr", mem_addr[u], BASE + 32'(4 * m_idx[u]));
          if (cell_valid[u]) begin
            chk("cell_data", cell_data[u], board[m_idx[u]]);
            chk("cell_row", 32'(cell_row[u]), 32'(m_idx[u] / 10));
            chk("cell_col", 32'(cell_col[u]), 32'(m_idx[u] % 10));
            chk("cell_last", 32'(cell_last[u]), 32'(m_idx[u] == N - 1));
            chk("cell_nz", 32'(nonzero_count[u]), 32'(nz_upto(m_idx[u] + 1)));
          end
        end else begin
          chk("idle_valid", 32'(cell_valid[u]), 0);
          chk("idle_read", 32'(mem_read[u]), 0);
        end
        if (m_done[u]) begin
          chk("done_nz", 32'(nonzero_count[u]), 32'(nz_upto(N)));
          done_cnt[u]++;
        end
        if (u == 0 && mem_read[0] && mem_data[0] == 32'hFFFF_FFFF) addr_q.push_back(mem_addr[0]);
        if (m_done[u]) begin
          m_done[u] = 1'b0;
        end else if (!m_busy[u]) begin
          if (start[u]) begin
            m_busy[u] = 1'b1;
            m_idx[u]  = 0;
          end
        end else if (abort[u]) begin
          m_busy[u] = 1'b0;
        end else if (cell_valid[u] && cell_ready[u]) begin
          if (cell_last[u]) last_cnt[u]++;
          m_idx[u]++;
          if (m_idx[u] == N) begin
            m_busy[u] = 1'b0;
            m_done[u] = 1'b1;
          end
        end
      end
    end
  end

  // Runs a scan from the start pulse to done; cyc counts cycles after the start cycle.
  task automatic scan(input int u, input bit rnd, input bit inject, output int cyc);
    bit seen37;
    bit fired;
    seen37 = 1'b0;
    fired  = 1'b0;
    @(posedge clk); #1 start[u] = 1'b1;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      start[u] = 1'b0;
      if (rnd) cell_ready[u] = 1'($urandom_range(0, 1));
      if (inject && seen37 && !fired) begin
        start[u] = 1'b1;
        fired    = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (cell_valid[u] && cell_row[u] == 4'd3 && cell_col[u] == 4'd7) seen37 = 1'b1;
      if (done[u]) break;
      if (cyc > 3000) begin
        checks++;
        errors++;
        $display("FAIL scan_timeout: unit %0d no done after %0d cycles", u, cyc);
        break;
      end
    end
    cell_ready[u] = 1'b1;
    #1;
  endtask

  initial begin
    int cyc;
    int d0;
    bit found;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      abort[u] = 1'b0;
      cell_ready[u] = 1'b1;
    end
    for (int i = 0; i < N; i++) board[i] = 32'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic scan, ready tied high
    scan(0, 1'b0, 1'b0, cyc);
    chk("t1_cycles", 32'(cyc), 201);
    chk("t1_nz", 32'(nonzero_count[0]), 99);
    chk("t1_dones", 32'(done_cnt[0]), 1);
    chk("t1_last", 32'(last_cnt[0]), 1);

    // Random back-pressure
    scan(0, 1'b1, 1'b0, cyc);
    chk("t2_nz", 32'(nonzero_count[0]), 99);
    chk("t2_dones", 32'(done_cnt[0]), 2);
    chk("t2_last", 32'(last_cnt[0]), 2);

    // Second start mid-scan is ignored
    scan(0, 1'b0, 1'b1, cyc);
    chk("t3_cycles", 32'(cyc), 201);
    chk("t3_dones", 32'(done_cnt[0]), 3);

    // Abort during PRESENT of cell 50 with ready high
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (mem_read[0] && mem_addr[0] == BASE + 32'd200) found = 1'b1;
    end
    chk("t4_reach50", 32'(found), 1);
    @(posedge clk); #1 abort[0] = 1'b1;
    @(negedge clk);
    chk("t4_pres_valid", 32'(cell_valid[0]), 1);
    chk("t4_pres_row", 32'(cell_row[0]), 5);
    chk("t4_pres_col", 32'(cell_col[0]), 0);
    @(posedge clk); #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(cell_valid[0]), 0);
    chk("t4_busy", 32'(busy[0]), 0);
    chk("t4_read", 32'(mem_read[0]), 0);
    chk("t4_nz", 32'(nonzero_count[0]), 50);
    #1 d0 = done_cnt[0];
    repeat (10) @(negedge clk);
    #1 chk("t4_no_done", 32'(done_cnt[0]), 32'(d0));
    scan(0, 1'b0, 1'b0, cyc);
    chk("t4_rescan_cycles", 32'(cyc), 201);
    chk("t4_rescan_nz", 32'(nonzero_count[0]), 99);
    chk("t4_rescan_dones", 32'(done_cnt[0]), 32'(d0 + 1));

    // Async reset during WAIT of cell 12 on the 3-cycle build
    @(posedge clk); #1 start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (mem_read[1] && mem_addr[1] == BASE + 32'd48 && rcnt[1] == 1) found = 1'b1;
    end
    chk("t5_reach_wait", 32'(found), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals(1, "t5_async");
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt[1];
    scan(1, 1'b0, 1'b0, cyc);
    chk("t5_cycles", 32'(cyc), 401);
    chk("t5_nz", 32'(nonzero_count[1]), 99);
    chk("t5_dones", 32'(done_cnt[1]), 32'(d0 + 1));

    // Sparse board
    for (int i = 0; i < N; i++) board[i] = 32'd0;
    board[0]  = 32'hFFFF_FFFF;
    board[55] = 32'hFFFF_FFFF;
    board[99] = 32'hFFFF_FFFF;
    addr_q.delete();
    scan(0, 1'b0, 1'b0, cyc);
    chk("t6_nz", 32'(nonzero_count[0]), 3);
    chk("t6_naddr", 32'(addr_q.size()), 3);
    if (addr_q.size() == 3) begin
      chk("t6_addr0", addr_q[0], 32'h1000);
      chk("t6_addr1", addr_q[1], 32'h10DC);
      chk("t6_addr2", addr_q[2], 32'h118C);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
